pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/hazard_sat_counter.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: increments on inc and holds at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use stalls, taken-branch squash, data-memory
// wait freeze with watchdog timeout, and saturating performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rt,
  input  logic                 mem_branch_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_write,
  output logic                 idex_flush,
  output logic                 exmem_write,
  output logic                 exmem_flush,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     cnt_loaduse,
  output logic [CNT_W-1:0]     cnt_flush,
  output logic [CNT_W-1:0]     cnt_wait
);

  localparam int              WC_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

  state_e          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            mem_stall;
  logic            load_use;
  logic            active;
  logic            win_branch;
  logic            win_loaduse;
  logic            win_wait;

  assign mem_stall = dmem_req && !dmem_ready;
  assign load_use  = ex_mem_read && (ex_rt != REG_ZERO) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign active    = (state != ERR);

  // A stalled MEM stage defers the branch; a taken branch overrides load-use.
  assign win_wait    = active && mem_stall;
  assign win_branch  = active && !mem_stall && mem_branch_taken;
  assign win_loaduse = active && !mem_stall && !mem_branch_taken && load_use;

  // Combinational so the enables gate the very edge they are computed for.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_write  = 1'b0;
    idex_flush  = 1'b0;
    exmem_write = 1'b0;
    exmem_flush = 1'b0;
    if (rst_n && active && !mem_stall) begin
      if (mem_branch_taken) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_write  = 1'b1;
        idex_flush  = 1'b1;
        exmem_write = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        idex_write  = 1'b1;
        idex_flush  = 1'b1;
        exmem_write = 1'b1;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WC_MAX) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WC_W'(1);
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= (state_nxt == ERR);
    end
  end

  hazard_sat_counter #(.W(CNT_W)) u_cnt_loaduse (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (win_loaduse),
    .cnt   (cnt_loaduse)
  );

  hazard_sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (win_branch),
    .cnt   (cnt_flush)
  );

  hazard_sat_counter #(.W(CNT_W)) u_cnt_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (win_wait),
    .cnt   (cnt_wait)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with a small timeout and narrow counters.
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
  logic             id_uses_rt = 1'b0, ex_mem_read = 1'b0, mem_branch_taken = 1'b0;
  logic             dmem_req = 1'b0, dmem_ready = 1'b0;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic             exmem_write, exmem_flush, mem_timeout;
  logic [CNT_W-1:0] cnt_loaduse, cnt_flush, cnt_wait;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .exmem_flush(exmem_flush),
    .mem_timeout(mem_timeout),
    .cnt_loaduse(cnt_loaduse), .cnt_flush(cnt_flush), .cnt_wait(cnt_wait)
  );

  // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, timeout, cnt_lu, cnt_fl, cnt_wt}
  typedef logic [8+3*CNT_W-1:0] vec_t;
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mr;
    logic [4:0] xrt;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  localparam stim_t IDLE = '0;

  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (0 RUN, 1 MEM_WAIT, 2 ERR) and its pending next value.
  int   m_st = 0, m_wc = 0, m_lu = 0, m_fl = 0, m_wt = 0;
  logic m_to = 1'b0;
  int   n_st, n_wc, n_lu, n_fl, n_wt;
  logic n_to;
  bit   pend = 1'b0;

  function automatic vec_t observe();
    return {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
            exmem_write, exmem_flush, mem_timeout, cnt_loaduse, cnt_flush, cnt_wait};
  endfunction

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    m_st = 0; m_wc = 0; m_lu = 0; m_fl = 0; m_wt = 0; m_to = 1'b0;
    pend = 1'b0;
  endtask

  task automatic drive(input stim_t s);
    logic       stall, lu;
    logic [6:0] ctl;
    @(negedge clk);
    if (pend) begin
      m_st = n_st; m_wc = n_wc; m_lu = n_lu; m_fl = n_fl; m_wt = n_wt; m_to = n_to;
    end
    id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt; ex_mem_read = s.mr; ex_rt = s.xrt;
    mem_branch_taken = s.br; dmem_req = s.req; dmem_ready = s.rdy;
    #1;
    stall = s.req && !s.rdy;
    lu    = s.mr && (s.xrt != 5'd0) && ((s.xrt == s.rs) || (s.urt && (s.xrt == s.rt)));
    if (!rst_n || m_st == 2 || stall) ctl = 7'b0000000;
    else if (s.br)                    ctl = 7'b1111111;
    else if (lu)                      ctl = 7'b0001110;
    else                              ctl = 7'b1101010;
    sb.push_back({ctl, m_to, CNT_W'(m_lu), CNT_W'(m_fl), CNT_W'(m_wt)});
    n_st = m_st; n_wc = m_wc; n_lu = m_lu; n_fl = m_fl; n_wt = m_wt; n_to = m_to;
    if (m_st != 2) begin
      if (stall)       n_wt = sat(m_wt);
      else if (s.br)   n_fl = sat(m_fl);
      else if (lu)     n_lu = sat(m_lu);
      if (m_st == 0) begin
        if (stall) begin n_st = 1; n_wc = 1; end
      end else if (s.rdy) begin
        n_st = 0; n_wc = 0;
      end else if (m_wc == MAX_WAIT) begin
        n_st = 2; n_to = 1'b1;
      end else begin
        n_wc = m_wc + 1;
      end
    end
    pend = 1'b1;
  endtask

  task automatic hit_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    sb.push_back(vec_t'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    {id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_branch_taken, dmem_req, dmem_ready} = IDLE;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    vec_t exp, obs;
    hit_reset();
    exp = sb.pop_front(); obs = observe(); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", obs, exp); end
    release_reset();
    drive(IDLE);
    exp = sb.pop_front(); obs = observe(); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, exp); end
  endtask

  task automatic test_load_use();
    stim_t t[$];
    vec_t  exp, obs;
    t.push_back('{rs:5'd8, rt:5'd0, urt:1'b0, mr:1'b1, xrt:5'd8, br:1'b0, req:1'b0, rdy:1'b0});
    t.push_back(IDLE);
    t.push_back(IDLE);
    foreach (t[i]) begin
      drive(t[i]);
      exp = sb.pop_front(); obs = observe(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL load_use[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_rt_and_zero();
    stim_t t[$];
    vec_t  exp, obs;
    t.push_back('{rs:5'd3, rt:5'd8, urt:1'b0, mr:1'b1, xrt:5'd8, br:1'b0, req:1'b0, rdy:1'b0});
    t.push_back('{rs:5'd3, rt:5'd8, urt:1'b1, mr:1'b1, xrt:5'd8, br:1'b0, req:1'b0, rdy:1'b0});
    t.push_back('{rs:5'd0, rt:5'd0, urt:1'b1, mr:1'b1, xrt:5'd0, br:1'b0, req:1'b0, rdy:1'b0});
    t.push_back('{rs:5'd9, rt:5'd4, urt:1'b1, mr:1'b0, xrt:5'd9, br:1'b0, req:1'b0, rdy:1'b0});
    t.push_back(IDLE);
    foreach (t[i]) begin
      drive(t[i]);
      exp = sb.pop_front(); obs = observe(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL rt_zero[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_branch();
    stim_t t[$];
    vec_t  exp, obs;
    t.push_back('{rs:5'd8, rt:5'd0, urt:1'b0, mr:1'b1, xrt:5'd8, br:1'b1, req:1'b0, rdy:1'b0});
    t.push_back(IDLE);
    foreach (t[i]) begin
      drive(t[i]);
      exp = sb.pop_front(); obs = observe(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL branch[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    vec_t  exp, obs;
    t.push_back('{rs:5'd0, rt:5'd0, urt:1'b0, mr:1'b0, xrt:5'd0, br:1'b1, req:1'b0, rdy:1'b0});
    t.push_back('{rs:5'd0, rt:5'd0, urt:1'b0, mr:1'b0, xrt:5'd0, br:1'b1, req:1'b1, rdy:1'b1});
    t.push_back('{rs:5'd5, rt:5'd0, urt:1'b0, mr:1'b1, xrt:5'd5, br:1'b0, req:1'b1, rdy:1'b1});
    t.push_back(IDLE);
    foreach (t[i]) begin
      drive(t[i]);
      exp = sb.pop_front(); obs = observe(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_mem_wait();
    stim_t t[$];
    vec_t  exp, obs;
    for (int k = 0; k < 3; k++)
      t.push_back('{rs:5'd0, rt:5'd0, urt:1'b0, mr:1'b0, xrt:5'd0, br:1'b1, req:1'b1, rdy:1'b0});
    t.push_back('{rs:5'd0, rt:5'd0, urt:1'b0, mr:1'b0, xrt:5'd0, br:1'b1, req:1'b1, rdy:1'b1});
    t.push_back(IDLE);
    foreach (t[i]) begin
      drive(t[i]);
      exp = sb.pop_front(); obs = observe(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL mem_wait[%0d]: got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_timeout();
    stim_t t[$];
    vec_t  exp, obs;
    hit_reset();
    exp = sb.pop_front(); obs = observe(); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL timeout_pre_reset: got %b expected %b", obs, exp); end
    release_reset();
    for (int k = 0; k < MAX_WAIT + 1; k++)
      t.push_back('{rs:5'd0, rt:5'd0, urt:1'b0, mr:1'b0, xrt:5'd0, br:1'b0, req:1'b1, rdy:1'b0});
    t.push_back('{rs:5'd0, rt:5'd0, urt:1'b0, mr:1'b0, xrt:5'd0, br:1'b1, req:1'b1, rdy:1'b1});
    t.push_back('{rs:5'd6, rt:5'd0, urt:1'b0, mr:1'b1, xrt:5'd6, br:1'b0, req:1'b0, rdy:1'b1});
    t.push_back(IDLE);
    foreach (t[i]) begin
      drive(t[i]);
      exp = sb.pop_front(); obs = observe(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL timeout[%0d]: got %b expected %b", i, obs, exp); end
    end
    hit_reset();
    exp = sb.pop_front(); obs = observe(); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL timeout_reset: got %b expected %b", obs, exp); end
    release_reset();
    drive(IDLE);
    exp = sb.pop_front(); obs = observe(); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL timeout_recover: got %b expected %b", obs, exp); end
  endtask

  task automatic test_saturation_reset();
    stim_t t[$];
    vec_t  exp, obs;
    hit_reset();
    exp = sb.pop_front(); obs = observe(); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL sat_pre_reset: got %b expected %b", obs, exp); end
    release_reset();
    for (int k = 0; k < 9; k++)
      t.push_back('{rs:5'd7, rt:5'd0, urt:1'b0, mr:1'b1, xrt:5'd7, br:1'b0, req:1'b0, rdy:1'b0});
    t.push_back(IDLE);
    t.push_back('{rs:5'd0, rt:5'd0, urt:1'b0, mr:1'b0, xrt:5'd0, br:1'b0, req:1'b1, rdy:1'b0});
    t.push_back('{rs:5'd0, rt:5'd0, urt:1'b0, mr:1'b0, xrt:5'd0, br:1'b0, req:1'b1, rdy:1'b0});
    t.push_back('{rs:5'd0, rt:5'd0, urt:1'b0, mr:1'b0, xrt:5'd0, br:1'b1, req:1'b1, rdy:1'b1});
    foreach (t[i]) begin
      drive(t[i]);
      exp = sb.pop_front(); obs = observe(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL saturation[%0d]: got %b expected %b", i, obs, exp); end
    end
    // Still in MEM_WAIT here; reset lands between clock edges.
    #2;
    hit_reset();
    exp = sb.pop_front(); obs = observe(); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL async_reset_mid_wait: got %b expected %b", obs, exp); end
    release_reset();
    drive(IDLE);
    exp = sb.pop_front(); obs = observe(); n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL async_reset_recover: got %b expected %b", obs, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_rt_and_zero();
    test_branch();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_saturation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
